regfile_mp: RTL and testbench

- Parametrised multi-port integer register file with a per-register pending scoreboard; the next generation of the core register file.
- Sits between decode (read and reserve) and writeback (write and release) in the frisc pipeline.
- Adds configurable width, depth and port counts, a hardwired zero register, deterministic write-conflict resolution, and hazard (busy) reporting per read port.

---
 rtl/regfile_pkg.sv | 34 +++
 rtl/regfile_mp_sb.sv | 74 +++++++
 rtl/regfile_mp.sv | 93 +++++++++
 tb/tb_regfile_mp.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: address-width helper,
// packed-port slice extraction and the hardwired zero-register address.
package regfile_pkg;

   // Widest packed port bundle the slice helpers can handle (e.g. 4 x 64 bits).
   localparam int unsigned MAX_BITS = 256;
   localparam int unsigned ZERO_ADDR = 0;

   typedef logic [MAX_BITS-1:0] pvec_t;

   // Address width for a given depth; never narrower than one bit.
   function automatic int unsigned calc_aw(input int unsigned depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   // Field i of width w from a packed bundle, right-aligned and zero-filled.
   function automatic pvec_t slice_at(input pvec_t vec, input int unsigned i,
                                      input int unsigned w);
      pvec_t mask;
      mask = (w >= MAX_BITS) ? '1 : ((pvec_t'(1) << w) - pvec_t'(1));
      return (vec >> (i * w)) & mask;
   endfunction

   function automatic pvec_t addr_at(input pvec_t vec, input int unsigned i,
                                     input int unsigned aw);
      return slice_at(vec, i, aw);
   endfunction

   function automatic pvec_t data_at(input pvec_t vec, input int unsigned i,
                                     input int unsigned width);
      return slice_at(vec, i, width);
   endfunction

endpackage

// File: rtl/regfile_mp_sb.sv
// Pending-result scoreboard: one bit per register, set by reserve, cleared by
// writeback (reserve wins on a tie), plus per-read-port busy lookup.
// REGFILE_BYPASS_EN: a same-cycle write to the read address hides the pending
// bit unless the same register is also being reserved this cycle.
module regfile_mp_sb
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned NREAD    = 2,
   parameter int unsigned NWRITE   = 1,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned AW       = calc_aw(DEPTH)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NWRITE-1:0]   wen,      // already masked for the zero register
   input  logic [NWRITE*AW-1:0] waddr,
   input  logic                rsv_en,
   input  logic [AW-1:0]       rsv_addr,
   input  logic [NREAD*AW-1:0] raddr,
   output logic [NREAD-1:0]    rbusy
);

   logic [DEPTH-1:0] pend_q, pend_d;
   logic [AW-1:0]    wa [NWRITE];
   logic [AW-1:0]    ra [NREAD];
   logic             rsv_ok;

   // Unpack port addresses and qualify the reserve request.
   always_comb begin
      for (int p = 0; p < NWRITE; p++) wa[p] = AW'(addr_at(pvec_t'(waddr), p, AW));
      for (int i = 0; i < NREAD; i++) ra[i] = AW'(addr_at(pvec_t'(raddr), i, AW));
      rsv_ok = rsv_en && !(ZERO_REG != 0 && rsv_addr == AW'(ZERO_ADDR));
   end

   // Next pending vector: clear on writeback, then set on reserve so a new
   // producer issuing as the old one retires keeps the register pending.
   always_comb begin
      pend_d = pend_q;
      for (int p = 0; p < NWRITE; p++) begin
         if (wen[p]) pend_d[wa[p]] = 1'b0;
      end
      if (rsv_ok) pend_d[rsv_addr] = 1'b1;
      if (reset) pend_d = '0;
   end

   // Pending vector register.
   always_ff @(posedge clk) begin
      pend_q <= pend_d;
   end

`ifdef REGFILE_BYPASS_EN
   logic [NREAD-1:0] fwd_hit;
`endif

   // Busy lookup per read port.
   always_comb begin
`ifdef REGFILE_BYPASS_EN
      fwd_hit = '0;
`endif
      rbusy = '0;
      for (int i = 0; i < NREAD; i++) begin
         rbusy[i] = pend_q[ra[i]];
`ifdef REGFILE_BYPASS_EN
         for (int p = 0; p < NWRITE; p++) begin
            if (wen[p] && wa[p] == ra[i]) fwd_hit[i] = 1'b1;
         end
         if (fwd_hit[i]) rbusy[i] = rsv_ok && (rsv_addr == ra[i]);
`endif
         if (ZERO_REG != 0 && ra[i] == AW'(ZERO_ADDR)) rbusy[i] = 1'b0;
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with hardwired zero register, deterministic
// write-conflict resolution (highest port wins) and a pending scoreboard.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned NREAD    = 2,
   parameter int unsigned NWRITE   = 1,
   parameter int unsigned ZERO_REG = 1,
   localparam int unsigned AW      = calc_aw(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NWRITE-1:0]      wen,
   input  logic [NWRITE*AW-1:0]   waddr,
   input  logic [NWRITE*WIDTH-1:0] wdata,
   input  logic [NREAD*AW-1:0]    raddr,
   output logic [NREAD*WIDTH-1:0] rdata,
   output logic [NREAD-1:0]       rbusy,
   input  logic                   rsv_en,
   input  logic [AW-1:0]          rsv_addr
);

   logic [WIDTH-1:0]  rf_q [DEPTH];
   logic [WIDTH-1:0]  rf_d [DEPTH];
   logic [AW-1:0]     wa [NWRITE];
   logic [WIDTH-1:0]  wd [NWRITE];
   logic [NWRITE-1:0] wen_eff;
   logic [AW-1:0]     ra [NREAD];
   logic [WIDTH-1:0]  rd_val [NREAD];

   // Unpack ports; writes to the zero register are dropped here.
   always_comb begin
      for (int p = 0; p < NWRITE; p++) begin
         wa[p]      = AW'(addr_at(pvec_t'(waddr), p, AW));
         wd[p]      = WIDTH'(data_at(pvec_t'(wdata), p, WIDTH));
         wen_eff[p] = wen[p] && !(ZERO_REG != 0 && wa[p] == AW'(ZERO_ADDR));
      end
      for (int i = 0; i < NREAD; i++) ra[i] = AW'(addr_at(pvec_t'(raddr), i, AW));
   end

   // Next array contents; ascending port order lets the higher port win.
   always_comb begin
      for (int r = 0; r < DEPTH; r++) rf_d[r] = rf_q[r];
      if (reset) begin
         for (int r = 0; r < DEPTH; r++) rf_d[r] = '0;
      end else begin
         for (int p = 0; p < NWRITE; p++) begin
            if (wen_eff[p]) rf_d[wa[p]] = wd[p];
         end
      end
   end

   // Data array register.
   always_ff @(posedge clk) begin
      for (int r = 0; r < DEPTH; r++) rf_q[r] <= rf_d[r];
   end

   // Combinational read ports, optionally forwarding same-cycle write data.
   always_comb begin
      rdata = '0;
      for (int i = 0; i < NREAD; i++) begin
         rd_val[i] = rf_q[ra[i]];
`ifdef REGFILE_BYPASS_EN
         for (int p = 0; p < NWRITE; p++) begin
            if (wen_eff[p] && wa[p] == ra[i]) rd_val[i] = wd[p];
         end
`endif
         if (ZERO_REG != 0 && ra[i] == AW'(ZERO_ADDR)) rd_val[i] = '0;
         rdata[i*WIDTH +: WIDTH] = rd_val[i];
      end
   end

   regfile_mp_sb #(
      .DEPTH    (DEPTH),
      .NREAD    (NREAD),
      .NWRITE   (NWRITE),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
   ) u_sb (
      .clk      (clk),
      .reset    (reset),
      .wen      (wen_eff),
      .waddr    (waddr),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .raddr    (raddr),
      .rbusy    (rbusy)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (2 read, 2 write ports, zero register on).
module tb_regfile_mp;

   localparam int W   = 32;
   localparam int D   = 32;
   localparam int NR  = 2;
   localparam int NW  = 2;
   localparam int AWB = 5;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [NW-1:0]     wen;
   logic [NW*AWB-1:0] waddr;
   logic [NW*W-1:0]   wdata;
   logic [NR*AWB-1:0] raddr;
   logic [NR*W-1:0]   rdata;
   logic [NR-1:0]     rbusy;
   logic              rsv_en;
   logic [AWB-1:0]    rsv_addr;

   int errors = 0;
   int checks = 0;

   // Reference state: register values and pending flags.
   logic [31:0] m_rf [D];
   bit          m_pend [D];

   always #5 clk = ~clk;

   regfile_mp #(
      .WIDTH    (W),
      .DEPTH    (D),
      .NREAD    (NR),
      .NWRITE   (NW),
      .ZERO_REG (1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .wen      (wen),
      .waddr    (waddr),
      .wdata    (wdata),
      .raddr    (raddr),
      .rdata    (rdata),
      .rbusy    (rbusy),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr)
   );

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wa0;
      logic [31:0] wd0;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic        rv;
      logic [4:0]  rva;
      logic [4:0]  p0;
      logic [4:0]  p1;
      logic [31:0] e0;
      logic [31:0] e1;
      logic        b0;
      logic        b1;
   } vec_t;

   localparam int NV = 9;
   vec_t tbl [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_rd(input int ra);
      logic [31:0] v;
      if (ra == 0) return 32'h0;
      v = m_rf[ra];
      if (BYP)
         for (int p = 0; p < NW; p++)
            if (wen[p] && int'(waddr[p*AWB +: AWB]) == ra) v = wdata[p*W +: W];
      return v;
   endfunction

   function automatic logic exp_bz(input int ra);
      bit hit;
      hit = 1'b0;
      if (ra == 0) return 1'b0;
      if (BYP)
         for (int p = 0; p < NW; p++)
            if (wen[p] && int'(waddr[p*AWB +: AWB]) == ra) hit = 1'b1;
      if (hit) return rsv_en && int'(rsv_addr) == ra;
      return m_pend[ra];
   endfunction

   task automatic check_model(input string tag);
      for (int i = 0; i < NR; i++) begin
         int ra;
         ra = int'(raddr[i*AWB +: AWB]);
         chk($sformatf("%s rdata%0d x%0d", tag, i, ra), rdata[i*W +: W], exp_rd(ra));
         chk($sformatf("%s rbusy%0d x%0d", tag, i, ra), {31'b0, rbusy[i]},
             {31'b0, exp_bz(ra)});
      end
   endtask

   // Apply the architectural effect of one clock edge to the reference state.
   task automatic model_edge();
      if (reset) begin
         for (int r = 0; r < D; r++) begin
            m_rf[r]   = 32'h0;
            m_pend[r] = 1'b0;
         end
      end else begin
         for (int p = 0; p < NW; p++) begin
            int a;
            a = int'(waddr[p*AWB +: AWB]);
            if (wen[p] && a != 0) m_rf[a] = wdata[p*W +: W];
            if (wen[p]) m_pend[a] = 1'b0;
         end
         if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                        input logic [4:0] wa1, input logic [31:0] wd1, input logic rv,
                        input logic [4:0] rva, input logic [4:0] p0, input logic [4:0] p1,
                        input logic rst);
      wen      = we;
      waddr    = {wa1, wa0};
      wdata    = {wd1, wd0};
      rsv_en   = rv;
      rsv_addr = rva;
      raddr    = {p1, p0};
      reset    = rst;
   endtask

   initial begin
      tbl[0] = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,  1'b0, 5'd0,  5'd5,  5'd0,
                 32'hDEADBEEF, 32'h0, 1'b0, 1'b0};
      tbl[1] = '{2'b11, 5'd7,  32'h11, 5'd7,  32'h22, 1'b0, 5'd0,  5'd7,  5'd5,
                 32'h22, 32'hDEADBEEF, 1'b0, 1'b0};
      tbl[2] = '{2'b01, 5'd0,  32'h1234, 5'd0, 32'h0, 1'b1, 5'd0,  5'd0,  5'd7,
                 32'h0, 32'h22, 1'b0, 1'b0};
      tbl[3] = '{2'b00, 5'd0,  32'h0, 5'd0,  32'h0,  1'b1, 5'd9,  5'd9,  5'd7,
                 32'h0, 32'h22, 1'b1, 1'b0};
      tbl[4] = '{2'b01, 5'd9,  32'h55, 5'd0,  32'h0,  1'b1, 5'd9,  5'd9,  5'd9,
                 32'h55, 32'h55, 1'b1, 1'b1};
      tbl[5] = '{2'b10, 5'd0,  32'h0, 5'd9,  32'h66, 1'b0, 5'd0,  5'd9,  5'd5,
                 32'h66, 32'hDEADBEEF, 1'b0, 1'b0};
      tbl[6] = '{2'b01, 5'd12, 32'hA5A5, 5'd0, 32'h0, 1'b0, 5'd0,  5'd12, 5'd9,
                 32'hA5A5, 32'h66, 1'b0, 1'b0};
      tbl[7] = '{2'b10, 5'd0,  32'h0, 5'd31, 32'h77, 1'b1, 5'd31, 5'd31, 5'd31,
                 32'h77, 32'h77, 1'b1, 1'b1};
      tbl[8] = '{2'b11, 5'd31, 32'h1, 5'd30, 32'h2,  1'b0, 5'd0,  5'd31, 5'd30,
                 32'h1, 32'h2, 1'b0, 1'b0};

      for (int r = 0; r < D; r++) begin
         m_rf[r]   = 32'hFFFF_FFFF;
         m_pend[r] = 1'b1;
      end

      // Reset with traffic present: must be ignored.
      drive(2'b11, 5'd4, 32'h1, 5'd6, 32'h2, 1'b1, 5'd4, 5'd0, 5'd0, 1'b1);
      @(negedge clk);
      tick();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      tick();

      // Every address reads zero and not busy.
      for (int a = 0; a < D; a++) begin
         raddr = {5'(D - 1 - a), 5'(a)};
         #1;
         chk($sformatf("reset rdata0 x%0d", a), rdata[31:0], 32'h0);
         chk($sformatf("reset rdata1 x%0d", D - 1 - a), rdata[63:32], 32'h0);
         chk($sformatf("reset rbusy x%0d", a), {30'b0, rbusy}, 32'h0);
      end

      // Same-cycle visibility of a write depends on forwarding.
      drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, 1'b0);
      #1;
      chk("x5 same cycle", rdata[31:0], BYP ? 32'hDEADBEEF : 32'h0);
      tick();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, 1'b0);
      #1;
      chk("x5 next cycle", rdata[31:0], 32'hDEADBEEF);

      // Vector table: check during the cycle against the model, then after the edge
      // against hand-derived constants.
      for (int k = 0; k < NV; k++) begin
         vec_t v;
         v = tbl[k];
         drive(v.we, v.wa0, v.wd0, v.wa1, v.wd1, v.rv, v.rva, v.p0, v.p1, 1'b0);
         #1;
         check_model($sformatf("vec%0d during", k));
         tick();
         wen    = 2'b00;
         rsv_en = 1'b0;
         #1;
         chk($sformatf("vec%0d rdata0", k), rdata[31:0], v.e0);
         chk($sformatf("vec%0d rdata1", k), rdata[63:32], v.e1);
         chk($sformatf("vec%0d rbusy0", k), {31'b0, rbusy[0]}, {31'b0, v.b0});
         chk($sformatf("vec%0d rbusy1", k), {31'b0, rbusy[1]}, {31'b0, v.b1});
         check_model($sformatf("vec%0d after", k));
      end

      // Reset mid-operation overrides a same-cycle write and reserve.
      drive(2'b01, 5'd3, 32'hAB, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd7, 1'b0);
      tick();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd7, 1'b0);
      tick();
      chk("x3 before reset", rdata[31:0], 32'hAB);
      chk("x3 busy before reset", {31'b0, rbusy[0]}, 32'h1);
      drive(2'b01, 5'd3, 32'h99, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd7, 1'b1);
      tick();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd7, 1'b0);
      #1;
      chk("x3 after reset", rdata[31:0], 32'h0);
      chk("x3 busy after reset", {31'b0, rbusy[0]}, 32'h0);
      chk("x7 after reset", rdata[63:32], 32'h0);

      // Randomised traffic against the reference model.
      for (int c = 0; c < 600; c++) begin
         logic [4:0] a [5];
         for (int j = 0; j < 5; j++)
            a[j] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                               : 5'($urandom_range(0, 7));
         drive(2'($urandom_range(0, 3)), a[0], $urandom, a[1], $urandom,
               1'($urandom_range(0, 1)), a[2], a[3], a[4], $urandom_range(0, 63) == 0);
         #1;
         check_model($sformatf("rand%0d", c));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
